// File: rtl/raymarch_pkg.sv
// Shared raymarcher definitions: frame geometry, colour packing and the
// dispatcher job/state types used by the raymarcher and display stages.
package raymarch_pkg;

  localparam int H_RES   = 640;
  localparam int V_RES   = 480;
  localparam int CORDW   = 10;
  localparam int COLOR_W = 10;
  localparam int ADDR_W  = 19;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } disp_state_e;

  typedef struct packed {
    logic [CORDW-1:0] x;
    logic [CORDW-1:0] y;
  } pix_job_t;

endpackage

// File: rtl/ray_pixel_dispatcher_fb_writeback.sv
// Result-to-framebuffer register stage: row-major address, range check and a
// one-cycle registered write port toward the M10K framebuffer.
module fb_writeback
  import raymarch_pkg::*;
#(
  parameter int H_ACTIVE = H_RES,
  parameter int V_ACTIVE = V_RES
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               res_valid,
  input  logic [CORDW-1:0]   res_x,
  input  logic [CORDW-1:0]   res_y,
  input  logic [COLOR_W-1:0] res_color,
  output logic               out_of_range,
  output logic               fb_we,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [COLOR_W-1:0] fb_data
);

  localparam logic [ADDR_W-1:0] LINE_PITCH = ADDR_W'(H_ACTIVE);

  logic [ADDR_W-1:0]  addr_p0;
  logic               vld_p1;
  logic [ADDR_W-1:0]  addr_p1;
  logic [COLOR_W-1:0] data_p1;

  // Constant multiply; at 640 pixels per line this reduces to (y<<9)+(y<<7)+x.
  assign addr_p0      = ADDR_W'(res_y) * LINE_PITCH + ADDR_W'(res_x);
  assign out_of_range = (int'(res_x) >= H_ACTIVE) || (int'(res_y) >= V_ACTIVE);

  // p0 -> p1: registered framebuffer write
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= res_valid && !out_of_range;
      if (res_valid && !out_of_range) begin
        addr_p1 <= addr_p0;
        data_p1 <= res_color;
      end
    end
  end

  assign fb_we   = vld_p1;
  assign fb_addr = addr_p1;
  assign fb_data = data_p1;

endmodule

// File: rtl/ray_pixel_dispatcher.sv
// Raster-order pixel job issuer with credit-limited in-flight count, result
// writeback into the framebuffer and frame completion signalling.
module ray_pixel_dispatcher
  import raymarch_pkg::*;
#(
  parameter int H_ACTIVE     = H_RES,
  parameter int V_ACTIVE     = V_RES,
  parameter int MAX_INFLIGHT = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               frame_start,
  output logic               busy,
  output logic               frame_done,
  output logic [15:0]        frame_count,
  output logic               job_valid,
  input  logic               job_ready,
  output logic [CORDW-1:0]   job_x,
  output logic [CORDW-1:0]   job_y,
  input  logic               res_valid,
  output logic               res_ready,
  input  logic [CORDW-1:0]   res_x,
  input  logic [CORDW-1:0]   res_y,
  input  logic [COLOR_W-1:0] res_color,
  output logic               fb_we,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [COLOR_W-1:0] fb_data,
  output logic [1:0]         err
);

  localparam int               INF_W   = $clog2(MAX_INFLIGHT) + 1;
  localparam logic [INF_W-1:0] INF_MAX = INF_W'(MAX_INFLIGHT);
  localparam logic [CORDW-1:0] X_LAST  = CORDW'(H_ACTIVE - 1);
  localparam logic [CORDW-1:0] Y_LAST  = CORDW'(V_ACTIVE - 1);

  disp_state_e      state, state_nxt;
  pix_job_t         job_q, job_nxt;
  logic [INF_W-1:0] inflight, inflight_nxt;
  logic             job_hs, res_hs, last_pix, range_err;

  assign res_ready  = reset_n;
  assign res_hs     = res_valid && res_ready;
  assign job_hs     = job_valid && job_ready;
  assign last_pix   = (job_q.x == X_LAST) && (job_q.y == Y_LAST);
  assign busy       = (state == ISSUE) || (state == DRAIN);
  assign frame_done = (state == DONE);
  assign job_x      = job_q.x;
  assign job_y      = job_q.y;

  always_comb begin
    state_nxt    = state;
    job_nxt      = job_q;
    inflight_nxt = inflight;
    case (state)
      IDLE:    if (frame_start) begin
                 state_nxt = ISSUE;
                 job_nxt   = '0;
               end
      ISSUE:   if (job_hs && last_pix) state_nxt = DRAIN;
      DRAIN:   if (inflight == '0 && !res_hs) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (job_hs) begin
      if (job_q.x == X_LAST) begin
        job_nxt.x = '0;
        job_nxt.y = last_pix ? '0 : job_q.y + 1'b1;
      end else begin
        job_nxt.x = job_q.x + 1'b1;
      end
    end
    // Simultaneous issue and return cancel; a stray return never underflows.
    if (job_hs && !res_hs)
      inflight_nxt = inflight + 1'b1;
    else if (!job_hs && res_hs && inflight != '0)
      inflight_nxt = inflight - 1'b1;
  end

  // Offer is derived from next-cycle state/credit so it drops on the very
  // handshake that fills the last credit or issues the last pixel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      job_q       <= '0;
      inflight    <= '0;
      job_valid   <= 1'b0;
      frame_count <= '0;
      err         <= '0;
    end else begin
      state     <= state_nxt;
      job_q     <= job_nxt;
      inflight  <= inflight_nxt;
      job_valid <= (state_nxt == ISSUE) && (inflight_nxt < INF_MAX);
      if (state == DONE) frame_count <= frame_count + 16'd1;
      if (res_hs && range_err) err[0] <= 1'b1;
      if (res_hs && inflight == '0) err[1] <= 1'b1;
    end
  end

  fb_writeback #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_fb_writeback (
    .clk          (clk),
    .reset_n      (reset_n),
    .res_valid    (res_hs),
    .res_x        (res_x),
    .res_y        (res_y),
    .res_color    (res_color),
    .out_of_range (range_err),
    .fb_we        (fb_we),
    .fb_addr      (fb_addr),
    .fb_data      (fb_data)
  );

endmodule

// File: tb/tb_ray_pixel_dispatcher.sv
// Bench for ray_pixel_dispatcher: small-frame instance checked every cycle
// against a job/credit/writeback model, plus a full-size instance for addressing.
module tb_ray_pixel_dispatcher;
  import raymarch_pkg::*;

  localparam int H    = 20;
  localparam int V    = 6;
  localparam int NPIX = H * V;
  localparam int MAXF = 16;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               frame_start = 1'b0;
  logic               job_ready = 1'b0;
  logic               res_valid = 1'b0;
  logic [CORDW-1:0]   res_x = '0, res_y = '0;
  logic [COLOR_W-1:0] res_color = '0;
  logic               busy, frame_done, job_valid, res_ready, fb_we;
  logic [15:0]        frame_count;
  logic [CORDW-1:0]   job_x, job_y;
  logic [ADDR_W-1:0]  fb_addr;
  logic [COLOR_W-1:0] fb_data;
  logic [1:0]         err;

  logic               hd_res_valid = 1'b0;
  logic [CORDW-1:0]   hd_res_x = '0, hd_res_y = '0;
  logic [COLOR_W-1:0] hd_res_color = '0;
  logic               hd_busy, hd_frame_done, hd_job_valid, hd_res_ready, hd_fb_we;
  logic [15:0]        hd_frame_count;
  logic [CORDW-1:0]   hd_job_x, hd_job_y;
  logic [ADDR_W-1:0]  hd_fb_addr;
  logic [COLOR_W-1:0] hd_fb_data;
  logic [1:0]         hd_err;

  always #10 clk = ~clk;

  ray_pixel_dispatcher #(.H_ACTIVE(H), .V_ACTIVE(V), .MAX_INFLIGHT(MAXF)) dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .busy(busy),
    .frame_done(frame_done), .frame_count(frame_count), .job_valid(job_valid),
    .job_ready(job_ready), .job_x(job_x), .job_y(job_y), .res_valid(res_valid),
    .res_ready(res_ready), .res_x(res_x), .res_y(res_y), .res_color(res_color),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .err(err)
  );

  ray_pixel_dispatcher dut_hd (
    .clk(clk), .reset_n(reset_n), .frame_start(1'b0), .busy(hd_busy),
    .frame_done(hd_frame_done), .frame_count(hd_frame_count), .job_valid(hd_job_valid),
    .job_ready(1'b0), .job_x(hd_job_x), .job_y(hd_job_y), .res_valid(hd_res_valid),
    .res_ready(hd_res_ready), .res_x(hd_res_x), .res_y(hd_res_y), .res_color(hd_res_color),
    .fb_we(hd_fb_we), .fb_addr(hd_fb_addr), .fb_data(hd_fb_data), .err(hd_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int color_of(input int x, input int y);
    return (x * 37 + y * 11) & 10'h3FF;
  endfunction

  // Core model: results waiting to be returned, one per cycle in order.
  typedef struct { int x; int y; int c; } res_t;
  res_t res_q[$];
  bit   auto_ret = 1'b0;

  task automatic push_res(input int x, input int y, input int c);
    res_t r;
    r.x = x; r.y = y; r.c = c;
    res_q.push_back(r);
  endtask

  initial begin : core
    res_t r;
    forever begin
      @(negedge clk);
      if (auto_ret && reset_n && job_valid && job_ready)
        push_res(int'(job_x), int'(job_y), color_of(int'(job_x), int'(job_y)));
      @(posedge clk); #1;
      if (res_q.size() > 0) begin
        r = res_q.pop_front();
        res_valid = 1'b1;
        res_x     = r.x[CORDW-1:0];
        res_y     = r.y[CORDW-1:0];
        res_color = r.c[COLOR_W-1:0];
      end else begin
        res_valid = 1'b0;
      end
    end
  end

  // Reference model: job index in the frame, outstanding credits, sticky errors.
  int         m_idx = 0, m_inf = 0, jobs_cnt = 0, done_cnt = 0;
  logic [1:0] m_err = '0;
  bit         p_j = 0, p_r = 0;
  int         p_x = 0, p_y = 0, p_c = 0;

  initial begin : compare
    bit exp_we, in_rng;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        m_idx = 0; m_inf = 0; m_err = '0; p_j = 0; p_r = 0;
      end else begin
        in_rng = (p_x < H) && (p_y < V);
        exp_we = p_r && in_rng;
        check("fb_we", fb_we, exp_we);
        if (exp_we) begin
          check("fb_addr", fb_addr, p_y * H + p_x);
          check("fb_data", fb_data, p_c);
        end
        if (p_r && !in_rng) m_err[0] = 1'b1;
        if (p_r && m_inf == 0) m_err[1] = 1'b1;
        if (p_j && !p_r) m_inf++;
        else if (!p_j && p_r && m_inf > 0) m_inf--;
        if (p_j) begin
          m_idx = (m_idx + 1) % NPIX;
          jobs_cnt++;
        end
        check("err", err, m_err);
        if (job_valid) begin
          check("job_x", job_x, m_idx % H);
          check("job_y", job_y, m_idx / H);
        end
        if (m_inf >= MAXF) check("job_valid_at_full_credit", job_valid, 0);
        if (frame_done) done_cnt++;
        p_j = job_valid && job_ready;
        p_r = res_valid;
        p_x = int'(res_x); p_y = int'(res_y); p_c = int'(res_color);
      end
    end
  end

  task automatic start_frame();
    @(posedge clk); #1; frame_start = 1'b1;
    @(posedge clk); #1; frame_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (frame_done) begin seen = 1'b1; break; end
    end
  endtask

  task automatic count_hs(input int cycles, output int c);
    c = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (job_valid && job_ready) c++;
    end
  endtask

  task automatic seek_job(input int x, input int y, input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (job_valid && int'(job_x) == x && int'(job_y) == y) begin found = 1'b1; break; end
    end
  endtask

  initial begin : stim
    bit seen, found;
    int cnt, j0, d0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_job_valid", job_valid, 0);
    check("rst_fb_we", fb_we, 0);
    check("rst_err", err, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_res_ready", res_ready, 0);
    check("rst_frame_done", frame_done, 0);
    @(posedge clk); #1; reset_n = 1'b1;
    @(negedge clk);
    check("res_ready_after_rst", res_ready, 1);
    check("idle_busy", busy, 0);

    // Full frame with an immediate-return core
    auto_ret = 1'b1; job_ready = 1'b1;
    j0 = jobs_cnt; d0 = done_cnt;
    start_frame();
    @(negedge clk);
    check("frame1_busy", busy, 1);
    check("frame1_first_x", job_x, 0);
    check("frame1_first_y", job_y, 0);
    wait_done(NPIX + 50, seen);
    check("frame1_done_seen", seen, 1);
    repeat (3) @(negedge clk);
    check("frame1_jobs", jobs_cnt - j0, NPIX);
    check("frame1_done_pulses", done_cnt - d0, 1);
    check("frame1_count", frame_count, 1);
    check("frame1_idle_busy", busy, 0);

    // Backpressure at (17,3)
    start_frame();
    seek_job(17, 3, 200, found);
    check("bp_reach", found, 1);
    job_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", job_valid, 1);
      check("bp_hold_x", job_x, 17);
      check("bp_hold_y", job_y, 3);
    end
    @(posedge clk); #1; job_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_next_x", job_x, 18);
    check("bp_next_y", job_y, 3);
    wait_done(NPIX + 50, seen);
    check("frame2_done_seen", seen, 1);
    repeat (2) @(negedge clk);
    check("frame2_count", frame_count, 2);

    // Credit limit: no returns
    auto_ret = 1'b0;
    start_frame();
    count_hs(40, cnt);
    check("credit_fill_jobs", cnt, MAXF);
    check("credit_stall_valid", job_valid, 0);
    #1; push_res(0, 0, color_of(0, 0));
    count_hs(10, cnt);
    check("credit_one_more", cnt, 1);
    @(posedge clk); #1; job_ready = 1'b0;
    @(negedge clk); #1;
    for (int i = 0; i < 10; i++) push_res(i, 1, color_of(i, 1));
    push_res(H, 0, 10'h0AA);
    repeat (15) @(negedge clk);
    check("oor_err0", err[0], 1);
    check("oor_err1_clear", err[1], 0);

    // Job and result handshakes in the same cycle at 5 in flight
    #1; push_res(5, 5, 10'h123);
    @(posedge clk); #1; job_ready = 1'b1;
    @(posedge clk); #1; job_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1; job_ready = 1'b1;
    count_hs(30, cnt);
    check("credit_after_simul", cnt, MAXF - 5);

    // Finish the frame, holding back the last result to sit in DRAIN
    #1;
    for (int i = 0; i < MAXF; i++) push_res(1, 1, color_of(1, 1));
    auto_ret = 1'b1;
    seek_job(H - 1, V - 1, 400, found);
    check("last_pixel_reach", found, 1);
    auto_ret = 1'b0;
    repeat (6) @(posedge clk);
    #1; frame_start = 1'b1;
    @(posedge clk); #1; frame_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("drain_busy", busy, 1);
      check("drain_no_job", job_valid, 0);
    end
    #1; push_res(H - 1, V - 1, color_of(H - 1, V - 1));
    wait_done(20, seen);
    check("frame3_done_seen", seen, 1);
    repeat (2) @(negedge clk);
    check("frame3_count", frame_count, 3);

    // Reset mid-frame at (10,3)
    auto_ret = 1'b1; job_ready = 1'b1;
    start_frame();
    seek_job(10, 3, 200, found);
    check("midrst_reach", found, 1);
    d0 = done_cnt;
    #1; reset_n = 1'b0; auto_ret = 1'b0; job_ready = 1'b0; res_q.delete();
    #1;
    check("midrst_job_valid", job_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_job_x", job_x, 0);
    check("midrst_job_y", job_y, 0);
    check("midrst_err", err, 0);
    check("midrst_frame_count", frame_count, 0);
    check("midrst_res_ready", res_ready, 0);
    repeat (3) @(posedge clk);
    #1; reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_idle", busy, 0);
    #1; push_res(3, 2, 10'h155);
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("late_fb_we", fb_we, 1);
    check("late_fb_addr", fb_addr, 43);
    check("late_fb_data", fb_data, 10'h155);
    check("late_err", err, 2'b10);

    // Full-size addressing on the 640x480 build
    check("hd_busy", hd_busy, 0);
    check("hd_job_valid", hd_job_valid, 0);
    check("hd_job_xy", {hd_job_x, hd_job_y}, 0);
    check("hd_frame", {hd_frame_done, hd_frame_count}, 0);
    check("hd_res_ready", hd_res_ready, 1);
    @(posedge clk); #1;
    hd_res_valid = 1'b1; hd_res_x = 10'd639; hd_res_y = 10'd479; hd_res_color = 10'h3FF;
    @(posedge clk); #1;
    hd_res_x = 10'd640; hd_res_y = 10'd0; hd_res_color = 10'h2AA;
    @(negedge clk);
    check("hd_corner_we", hd_fb_we, 1);
    check("hd_corner_addr", hd_fb_addr, 307199);
    check("hd_corner_data", hd_fb_data, 10'h3FF);
    @(posedge clk); #1;
    hd_res_x = 10'd5; hd_res_y = 10'd2; hd_res_color = 10'h0F0;
    @(negedge clk);
    check("hd_oor_we", hd_fb_we, 0);
    check("hd_oor_err", hd_err, 2'b11);
    @(posedge clk); #1; hd_res_valid = 1'b0;
    @(negedge clk);
    check("hd_mid_we", hd_fb_we, 1);
    check("hd_mid_addr", hd_fb_addr, 1285);
    check("hd_mid_data", hd_fb_data, 10'h0F0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
